// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: one request at a time, split into
// little-endian single-byte memory transactions, one per clock.
module lsu_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic [31:0]       rbuf_nxt;
   logic [31:0]       ld_word;
   logic [1:0]        k;
   logic [1:0]        last;
   logic              accept;
   logic              legal;
   logic              last_byte;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && (state == IDLE);
   assign last_byte  = (k == last);

   // Loads reject 011/11x, stores accept only 000/001/010.
   assign legal = (req_funct3[1:0] != 2'b11) &&
                  (req_we ? !req_funct3[2]
                          : !(req_funct3[2] && req_funct3[1]));

   always_comb begin
      last = 2'd3;
      case (f3_q[1:0])
         2'b00:   last = 2'd0;
         2'b01:   last = 2'd1;
         default: last = 2'd3;
      endcase
   end

   always_comb begin
      rbuf_nxt = rbuf;
      rbuf_nxt[{k, 3'b000} +: 8] = mem_rdata;
   end

   always_comb begin
      ld_word = rbuf_nxt;
      case (f3_q)
         3'b000:  ld_word = {{24{rbuf_nxt[7]}}, rbuf_nxt[7:0]};
         3'b001:  ld_word = {{16{rbuf_nxt[15]}}, rbuf_nxt[15:0]};
         3'b100:  ld_word = {24'd0, rbuf_nxt[7:0]};
         3'b101:  ld_word = {16'd0, rbuf_nxt[15:0]};
         default: ld_word = rbuf_nxt;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = legal ? XFER : RESP;
         end
         XFER: begin
            if (last_byte) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are gated by rst so the byte of an aborted cycle is never written.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_wdata = 8'd0;
      if (state == XFER && !rst) begin
         mem_addr  = base + {{(ADDR_W-2){1'b0}}, k};
         mem_we    = we_q;
         mem_re    = !we_q;
         mem_wdata = wdata_q[{k, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         base       <= '0;
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         wdata_q    <= 32'd0;
         rbuf       <= 32'd0;
         k          <= 2'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            base    <= req_addr;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            rbuf    <= 32'd0;
            k       <= 2'd0;
            if (!legal) begin
               resp_rdata <= 32'd0;
               resp_err   <= 1'b1;
            end
         end
         if (state == XFER) begin
            k <= k + 2'd1;
            if (!we_q) rbuf <= rbuf_nxt;
            if (last_byte) begin
               resp_rdata <= we_q ? 32'd0 : ld_word;
               resp_err   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a 256-byte memory model
// and a log of every byte write the sequencer issues.
module tb_lsu_byte_sequencer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  tmem [256];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [7:0]  pre_data;
   logic [31:0] wa_q [$];
   logic [7:0]  wd_q [$];

   int n_chk;
   int n_pass;

   lsu_byte_sequencer #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = tmem[mem_addr[7:0]];

   always @(posedge clk) begin
      if (pre_we) begin
         tmem[pre_addr] <= pre_data;
      end else if (mem_we) begin
         tmem[mem_addr[7:0]] <= mem_wdata;
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   // lat: cycle index (1 = first cycle after accept) where resp_valid rose.
   task automatic run_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic err, output int nwe, output int nre);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      tick();
      req_valid = 1'b0;
      lat = 1;
      nwe = 0;
      nre = 0;
      while (!resp_valid && lat < 12) begin
         nwe = nwe + int'(mem_we);
         nre = nre + int'(mem_re);
         tick();
         lat = lat + 1;
      end
      if (!resp_valid) lat = -1;
      rd  = resp_rdata;
      err = resp_err;
   endtask

   initial begin
      int          lat;
      int          nwe;
      int          nre;
      int          wn;
      int          seen;
      int          nlow;
      logic [31:0] rd;
      logic        err;
      logic [7:0]  exp_b [4];

      n_chk      = 0;
      n_pass     = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      pre_we     = 1'b0;
      pre_addr   = 8'd0;
      pre_data   = 8'd0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);

      preload(8'h21, 8'h80);
      preload(8'h30, 8'h01);
      preload(8'h31, 8'h80);
      preload(8'h40, 8'h00);
      preload(8'h41, 8'h00);
      preload(8'h42, 8'h77);
      preload(8'h43, 8'h66);

      wn = wa_q.size();
      run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, err, nwe, nre);
      chk("sw_latency", 32'(lat), 32'd5);
      chk("sw_err", 32'(err), 32'd0);
      chk("sw_rdata", rd, 32'd0);
      chk("sw_we_cycles", 32'(nwe), 32'd4);
      chk("sw_nwrites", 32'(wa_q.size() - wn), 32'd4);
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 4; i++) begin
         if (wn + i < wa_q.size()) begin
            chk($sformatf("sw_addr%0d", i), wa_q[wn+i], 32'h10 + 32'(i));
            chk($sformatf("sw_data%0d", i), 32'(wd_q[wn+i]), 32'(exp_b[i]));
         end
      end
      tick();

      run_req(1'b0, 3'b000, 32'h21, 32'd0, lat, rd, err, nwe, nre);
      chk("lb_rdata", rd, 32'hFFFFFF80);
      chk("lb_latency", 32'(lat), 32'd2);
      chk("lb_re_cycles", 32'(nre), 32'd1);
      tick();
      run_req(1'b0, 3'b100, 32'h21, 32'd0, lat, rd, err, nwe, nre);
      chk("lbu_rdata", rd, 32'h00000080);
      tick();
      run_req(1'b0, 3'b001, 32'h30, 32'd0, lat, rd, err, nwe, nre);
      chk("lh_rdata", rd, 32'hFFFF8001);
      chk("lh_latency", 32'(lat), 32'd3);
      chk("lh_re_cycles", 32'(nre), 32'd2);
      tick();
      run_req(1'b0, 3'b101, 32'h30, 32'd0, lat, rd, err, nwe, nre);
      chk("lhu_rdata", rd, 32'h00008001);
      chk("lhu_err", 32'(err), 32'd0);
      tick();

      wn = wa_q.size();
      run_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A, lat, rd, err,
              nwe, nre);
      chk("sh_wrap_latency", 32'(lat), 32'd3);
      chk("sh_wrap_nwrites", 32'(wa_q.size() - wn), 32'd2);
      if (wa_q.size() >= wn + 2) begin
         chk("sh_wrap_addr0", wa_q[wn], 32'hFFFFFFFF);
         chk("sh_wrap_data0", 32'(wd_q[wn]), 32'h5A);
         chk("sh_wrap_addr1", wa_q[wn+1], 32'h00000000);
         chk("sh_wrap_data1", 32'(wd_q[wn+1]), 32'hA5);
      end
      tick();
      run_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'd0, lat, rd, err, nwe, nre);
      chk("lhu_wrap_rdata", rd, 32'h0000A55A);
      tick();

      run_req(1'b0, 3'b011, 32'h21, 32'd0, lat, rd, err, nwe, nre);
      chk("ill_ld_latency", 32'(lat), 32'd1);
      chk("ill_ld_err", 32'(err), 32'd1);
      chk("ill_ld_rdata", rd, 32'd0);
      chk("ill_ld_re", 32'(nre), 32'd0);
      tick();
      chk("ill_ld_ready_after", 32'(req_ready), 32'd1);
      chk("ill_ld_err_held", 32'(resp_err), 32'd1);
      wn = wa_q.size();
      run_req(1'b1, 3'b100, 32'h21, 32'hFFFFFFFF, lat, rd, err, nwe, nre);
      chk("ill_st_latency", 32'(lat), 32'd1);
      chk("ill_st_err", 32'(err), 32'd1);
      chk("ill_st_rdata", rd, 32'd0);
      chk("ill_st_nwrites", 32'(wa_q.size() - wn), 32'd0);
      tick();

      wn = wa_q.size();
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h40;
      req_wdata  = 32'h11223344;
      req_valid  = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_resp_rdata", resp_rdata, 32'd0);
      chk("abort_resp_err", 32'(resp_err), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_nwrites", 32'(wa_q.size() - wn), 32'd2);
      if (wa_q.size() >= wn + 2) begin
         chk("abort_addr0", wa_q[wn], 32'h40);
         chk("abort_data0", 32'(wd_q[wn]), 32'h44);
         chk("abort_addr1", wa_q[wn+1], 32'h41);
         chk("abort_data1", 32'(wd_q[wn+1]), 32'h33);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         seen = seen + int'(resp_valid);
         tick();
      end
      chk("abort_no_resp", 32'(seen), 32'd0);
      run_req(1'b0, 3'b010, 32'h40, 32'd0, lat, rd, err, nwe, nre);
      chk("abort_lw_rdata", rd, 32'h66773344);
      chk("abort_lw_latency", 32'(lat), 32'd5);
      tick();

      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      req_valid  = 1'b1;
      chk("b2b_ready0", 32'(req_ready), 32'd1);
      tick();
      nlow = 0;
      rd   = 32'd0;
      while (!req_ready && nlow < 20) begin
         if (resp_valid) rd = resp_rdata;
         nlow = nlow + 1;
         tick();
      end
      chk("b2b_low_cycles", 32'(nlow), 32'd5);
      chk("b2b_rdata0", rd, 32'hDEADBEEF);
      req_addr = 32'h40;
      tick();
      req_valid = 1'b0;
      chk("b2b_accept1", 32'(req_ready), 32'd0);
      lat = 1;
      while (!resp_valid && lat < 12) begin
         tick();
         lat = lat + 1;
      end
      if (!resp_valid) lat = -1;
      chk("b2b_latency1", 32'(lat), 32'd5);
      chk("b2b_rdata1", resp_rdata, 32'h66773344);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
